// File: rtl/conditioned_shifter_pkg.sv
// Shared constants for the conditioned shifter: direction encoding, input-channel
// indices and the per-cycle operation chosen from the conditioned pulses.
package conditioned_shifter_pkg;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam int CH_LOAD   = 0;
    localparam int CH_SERIAL = 1;
    localparam int CH_SHIFT  = 2;
    localparam int CH_DIR    = 3;
    localparam int NUM_CH    = 4;

    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_LOAD  = 2'd1,
        OP_SHIFT = 2'd2
    } shift_op_e;

    // A load pulse always wins over a shift pulse arriving in the same cycle.
    function automatic shift_op_e resolve_op(input logic load_pulse, input logic shift_pulse);
        if (load_pulse) begin
            return OP_LOAD;
        end else if (shift_pulse) begin
            return OP_SHIFT;
        end
        return OP_NONE;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One raw board input: 2-flop synchroniser, stability counter and registered
// one-cycle edge pulses that coincide with the conditioned value changing.
module debounce_channel
    import conditioned_shifter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic conditioned,
    output logic posedge_pulse,
    output logic negedge_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             cond_q,  cond_d;
    logic             rise_q,  rise_d;
    logic             fall_q,  fall_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    // The counter must already hold DEBOUNCE_CYCLES before the toggle, so a raw
    // change stable from edge N shows up on edge N+2+DEBOUNCE_CYCLES.
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        cnt_d   = '0;
        cond_d  = cond_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync2_q != cond_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
                cond_d = ~cond_q;
                rise_d = ~cond_q;
                fall_d = cond_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            cond_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            cond_q  <= cond_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign conditioned   = cond_q;
    assign posedge_pulse = rise_q;
    assign negedge_pulse = fall_q;

endmodule

// File: rtl/conditioned_shifter.sv
// Button/switch conditioned bidirectional shift register with load, shift counter
// and frame pulse. Define CONDITIONED_SHIFTER_PARITY_EN to register parity_out.
module conditioned_shifter
    import conditioned_shifter_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         btn_load,
    input  logic                         sw_serial_in,
    input  logic                         sw_shift,
    input  logic                         sw_dir,
    input  logic [WIDTH-1:0]             parallel_in,
    output logic [WIDTH-1:0]             parallel_out,
    output logic                         serial_out,
    output logic [$clog2(WIDTH+1)-1:0]   shift_count,
    output logic                         frame_done,
    output logic                         parity_out
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [NUM_CH-1:0] raw_vec;
    logic [NUM_CH-1:0] cond_vec;
    logic [NUM_CH-1:0] rise_vec;
    logic [NUM_CH-1:0] fall_vec;

    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             frame_q, frame_d;
    shift_op_e        op;

    assign raw_vec[CH_LOAD]   = btn_load;
    assign raw_vec[CH_SERIAL] = sw_serial_in;
    assign raw_vec[CH_SHIFT]  = sw_shift;
    assign raw_vec[CH_DIR]    = sw_dir;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk           (clk),
            .rst_n         (rst_n),
            .raw           (raw_vec[i]),
            .conditioned   (cond_vec[i]),
            .posedge_pulse (rise_vec[i]),
            .negedge_pulse (fall_vec[i])
        );
    end

    // Loads fire on button release; shifts on the rising edge of the shift switch.
    assign op = resolve_op(fall_vec[CH_LOAD], rise_vec[CH_SHIFT]);

    always_comb begin
        data_d  = data_q;
        count_d = count_q;
        frame_d = 1'b0;
        unique case (op)
            OP_LOAD: begin
                data_d  = parallel_in;
                count_d = '0;
            end
            OP_SHIFT: begin
                if (cond_vec[CH_DIR] == DIR_RIGHT) begin
                    data_d = {cond_vec[CH_SERIAL], data_q[WIDTH-1:1]};
                end else begin
                    data_d = {data_q[WIDTH-2:0], cond_vec[CH_SERIAL]};
                end
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    count_d = '0;
                    frame_d = 1'b1;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            count_q <= '0;
            frame_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            count_q <= count_d;
            frame_q <= frame_d;
        end
    end

`ifdef CONDITIONED_SHIFTER_PARITY_EN
    logic parity_q, parity_d;

    always_comb begin
        parity_d = parity_q;
        if (op != OP_NONE) begin
            parity_d = ^data_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign parity_out = parity_q;
`else
    assign parity_out = 1'b0;
`endif

    logic unused_pulses;
    assign unused_pulses = ^{rise_vec[CH_LOAD], fall_vec[CH_SHIFT],
                             rise_vec[CH_SERIAL], fall_vec[CH_SERIAL],
                             rise_vec[CH_DIR], fall_vec[CH_DIR],
                             cond_vec[CH_LOAD], cond_vec[CH_SHIFT]};

    assign parallel_out = data_q;
    assign shift_count  = count_q;
    assign frame_done   = frame_q;
    assign serial_out   = (cond_vec[CH_DIR] == DIR_LEFT) ? data_q[WIDTH-1] : data_q[0];

endmodule
